// File: rtl/div_unit_pkg.sv
// Shared encodings for the divide unit: ALU opcodes that start a divide
// and the 2-bit FSM state codes.
package div_unit_pkg;

  localparam logic [7:0] DIV_OP  = 8'h1A;
  localparam logic [7:0] DIVU_OP = 8'h1B;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  localparam int unsigned DIV_STEPS = 32;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (signed/unsigned, 32-bit) producing
// {HI=remainder, LO=quotient}; one quotient bit per cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrol,
  input  logic        start,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result,
  output logic        div_zero,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken only in IDLE when start=1, annul=0 and the
  // opcode is DIV/DIVU; ready pulses one cycle (with div_zero) when result is
  // updated, and nothing else is accepted while busy=1.

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] pr_q, pr_d;
  logic [32:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        div_zero_q, div_zero_d;

  logic        is_div_op;
  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  assign is_div_op = (alucontrol == DIV_OP) || (alucontrol == DIVU_OP);
  assign is_signed = (alucontrol == DIV_OP);
  assign abs_a     = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign abs_b     = (is_signed && b[31]) ? (32'd0 - b) : b;

  // The single 33-bit trial subtract; a clear borrow bit means the divisor fits.
  assign shifted = {pr_q[63:0], 1'b0};
  assign trial   = shifted[64:32] - dvsr_q;

  assign quo_fix = neg_quo_q ? (32'd0 - pr_q[31:0])  : pr_q[31:0];
  assign rem_fix = neg_rem_q ? (32'd0 - pr_q[63:32]) : pr_q[63:32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pr_d       = pr_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    result_d   = result_q;
    ready_d    = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && is_div_op) begin
          pr_d      = {33'd0, abs_a};
          dvsr_d    = {1'b0, abs_b};
          neg_quo_d = is_signed && (a[31] ^ b[31]);
          neg_rem_d = is_signed && a[31];
          dz_d      = (b == 32'd0);
          cnt_d     = 6'd0;
          state_d   = (b == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_ON: begin
        pr_d  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) state_d = S_END;
      end
      S_DIVZERO: begin
        state_d = S_END;
      end
      S_END: begin
        state_d    = S_IDLE;
        ready_d    = 1'b1;
        div_zero_d = dz_q;
        result_d   = dz_q ? 64'd0 : {rem_fix, quo_fix};
      end
      default: state_d = S_IDLE;
    endcase

    // A flush cancels whatever was in flight, including a request this cycle.
    if (annul) begin
      state_d    = S_IDLE;
      cnt_d      = 6'd0;
      ready_d    = 1'b0;
      div_zero_d = 1'b0;
      result_d   = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      pr_q       <= 65'd0;
      dvsr_q     <= 33'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pr_q       <= pr_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ready     = ready_q;
  assign div_zero  = div_zero_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alucontrol  input  8  ALU operation code; only the DIV_OP and DIVU_OP encodings from defines.vh start an operation.
REQ-005 start  input  1  request; qualified with a DIV or DIVU alucontrol.
REQ-006 annul  input  1  pipeline flush; cancels any operation in flight.
REQ-007 a  input  32  dividend (rs).
REQ-008 b  input  32  divisor (rt).
REQ-009 busy  output  1  high while an operation is in flight (states ON, DIVZERO, END).
REQ-010 ready  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  64  {HI = remainder[63:32], LO = quotient[31:0]}.
REQ-012 div_zero  output  1  high together with ready when b was 0.

Function
REQ-013 FSM states SHALL be: IDLE, DIVZERO, ON, END.
REQ-014 IDLE: on start=1, annul=0 and alucontrol in {DIV_OP, DIVU_OP}:
- latch operands and signedness (DIV_OP = signed);
- go to DIVZERO if b==0, else ON.
REQ-015 IDLE: start with any other alucontrol SHALL be ignored.
REQ-016 start while busy=1 SHALL be ignored; latched operands SHALL stay stable until END.
REQ-017 Signed mode: operands SHALL be converted to magnitudes before iterating.
- quotient negated iff operand signs differ;
- remainder carries the dividend's sign.
REQ-018 ON SHALL perform a radix-2 restoring step per cycle:
- 65-bit partial-remainder/quotient register, shift left, trial subtract of the 33-bit divisor;
- 6-bit counter; exactly 32 cycles, then go to END.
REQ-019 DIVZERO SHALL last one cycle, then go to END with result=0 and div_zero=1.
REQ-020 END SHALL assert ready=1 for exactly one cycle with the sign-corrected result, then return to IDLE.
REQ-021 Latency, from the edge accepting start:
- b!=0: ready asserted 33 cycles later;
- b==0: ready asserted 2 cycles later.
REQ-022 result SHALL hold its last value after END until the next END; it SHALL be 0 after reset.
REQ-023 annul=1 in any state SHALL force IDLE at the next edge; no ready pulse SHALL follow for the cancelled operation.
REQ-024 annul and start together in IDLE: annul SHALL win, no operation starts.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, with no exception flag.
REQ-026 Outputs busy, ready and div_zero SHALL be registered or decoded from state only; no combinational path from a or b.

Reset
REQ-027 rst=1 at an edge SHALL force:
- state IDLE, counter 0;
- busy=0, ready=0, div_zero=0, result=0.
REQ-028 rst mid-operation SHALL discard the operation with no ready pulse; rst SHALL take priority over start and annul.

Structure
REQ-029 DIV_OP/DIVU_OP encodings and the four state encodings (2-bit) SHALL live in shared defines.vh.
REQ-030 Block SHALL be a single module, no sub-modules; the datapath SHALL be one 65-bit shift register plus one 33-bit subtractor.

Verification
REQ-031 DIVU, a=100, b=7 -> ready 33 cycles after start, result={0x00000002,0x0000000E}, div_zero=0.
REQ-032 DIV, a=0xFFFFFFF9 (-7), b=2 -> result={0xFFFFFFFF,0xFFFFFFFD}.
REQ-033 DIV, a=0x80000000, b=0xFFFFFFFF -> result={0x00000000,0x80000000}.
REQ-034 DIVU, a=5, b=0 -> ready 2 cycles after start, div_zero=1, result=0.
REQ-035 DIVU a=100, b=7; annul at cycle 10 -> busy=0 next cycle, no ready within 40 cycles.
REQ-036 Second start with a=1,b=1 at cycle 5 of a running DIVU 100/7 -> ignored, result={2,14}; rst at cycle 20 -> all outputs 0, no ready.
